pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Each cycle it generates the pause/clear controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- It resolves four conditions:
  - load-use data hazards;
  - taken-branch flushes;
  - shared instruction/data RAM structural conflicts;
  - multi-cycle RAM waits.
- It also keeps a stall-cycle counter and a RAM-timeout flag.

Parameters:
- REG_ADDR_W, 4, register index width.
- BR_FLUSH, 2, cycles of IF/ID squash after a taken branch (1..7).
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout sets (≥2).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs_valid  in  1  ID instruction reads rs.
- id_rs_addr  in  REG_ADDR_W  ID rs index.
- id_rt_valid  in  1  ID instruction reads rt.
- id_rt_addr  in  REG_ADDR_W  ID rt index.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd_addr  in  REG_ADDR_W  EX destination index.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_data_access  in  1  MEM stage uses the shared RAM this cycle.
- mem_ready  in  1  RAM completes the MEM access this cycle.
- pc_pause  out  1  hold PC.
- if_id_pause  out  1  hold IF/ID.
- if_id_clear  out  1  load bubble into IF/ID.
- id_ex_pause  out  1  hold ID/EX.
- id_ex_clear  out  1  load bubble into ID/EX.
- ex_mem_pause  out  1  hold EX/MEM.
- mem_wb_clear  out  1  load bubble into MEM/WB.
- stall_cnt  out  CNT_W  cycles with pc_pause=1, saturating.
- mem_timeout  out  1  sticky RAM-timeout flag.

Behaviour:
- Encoding and timing:
  - All pause/clear outputs are 1 = enable.
  - Downstream registers give pause priority over clear.
  - Outputs are combinational from state and current inputs; state, counters and flags update on the rising clk edge.
- Reset:
  - While rst=1: state=RUN, flush_cnt=0, wait_cnt=0, stall_cnt=0, mem_timeout=0.
  - Outputs forced to: all pauses 0; if_id_clear=1, id_ex_clear=1, mem_wb_clear=1.
  - rst asserted in any state (including MEM_WAIT) returns to RUN on the next edge.
- States: RUN, FLUSH, MEM_WAIT. Priority within a cycle: rst > MEM_WAIT condition > branch > load-use > structural.
- MEM_WAIT entry:
  - Condition: mem_data_access=1 and mem_ready=0, from any state.
  - Full freeze: pc/if_id/id_ex/ex_mem pause=1, mem_wb_clear=1, all other clears 0.
  - The same outputs apply in the entry cycle itself.
  - The state records its return state (RUN or FLUSH); flush_cnt is preserved.
- MEM_WAIT operation:
  - wait_cnt increments each MEM_WAIT cycle; it is cleared on entry.
  - When wait_cnt reaches MEM_TIMEOUT-1, mem_timeout sets and stays set until rst.
  - The state machine still waits on mem_ready.
- MEM_WAIT exit:
  - On the cycle mem_ready=1: the freeze ends and outputs follow the RUN/FLUSH rules for that cycle.
  - The state returns to the recorded state.
- Branch (RUN, ex_branch_taken=1):
  - Outputs: if_id_clear=1, id_ex_clear=1, pc_pause=0.
  - If BR_FLUSH>1: next state FLUSH with flush_cnt=BR_FLUSH-1.
  - Branch overrides a simultaneous load-use and structural conflict; no stall is counted.
- FLUSH:
  - Outputs: if_id_clear=1, other controls 0.
  - flush_cnt decrements per non-frozen cycle; the state returns to RUN when flush_cnt reaches 0.
  - Load-use is ignored (ID holds a bubble).
  - A structural conflict additionally sets pc_pause=1.
- Load-use (RUN):
  - Condition: ex_mem_read=1, ex_rd_addr≠0, and (id_rs_valid with rs==rd, or id_rt_valid with rt==rd).
  - Outputs: pc_pause=1, if_id_pause=1, id_ex_clear=1, for exactly one cycle.
- Structural (RUN, mem_data_access=1, mem_ready=1, no higher condition): pc_pause=1, if_id_clear=1.
- No condition active: all outputs 0.
- stall_cnt increments by 1 on each edge where pc_pause=1 (any cause, including freeze); it saturates at all-ones.

Test Plan:
1. rst=1 for 2 cycles, then 0 with all inputs 0 → stall_cnt=0, mem_timeout=0, all outputs 0 in cycle 1.
2. Load-use: ex_mem_read=1, ex_rd_addr=3, id_rs_valid=1, id_rs_addr=3, for 1 cycle → pc_pause=1, if_id_pause=1, id_ex_clear=1 in that cycle only; stall_cnt=1. Repeat with rd=0 → no stall.
3. ex_branch_taken=1 plus the same-cycle load-use match from scenario 2, BR_FLUSH=2 → cycle 0: if_id_clear=1, id_ex_clear=1, pc_pause=0; cycle 1: if_id_clear=1 only; cycle 2: all 0; stall_cnt unchanged.
4. mem_data_access=1, mem_ready=0 for 5 cycles, then mem_ready=1 → 5 frozen cycles (four pauses=1, mem_wb_clear=1); the ready cycle gives pc_pause=1, if_id_clear=1; stall_cnt=6.
5. mem_data_access=1, mem_ready=0 held for MEM_TIMEOUT+2 cycles → mem_timeout rises after cycle MEM_TIMEOUT and stays 1 after mem_ready; only rst clears it.
6. Branch with BR_FLUSH=3, then a RAM wait of 3 cycles in FLUSH cycle 1 → after the wait, exactly 1 remaining if_id_clear cycle, then RUN. Asserting rst mid-MEM_WAIT → RUN next edge, with counters and mem_timeout cleared.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: generates pause/clear controls for
// load-use, taken-branch, shared-RAM structural conflicts and RAM waits.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int BR_FLUSH    = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_rs_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic                  id_rt_valid,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_data_access,
  input  logic                  mem_ready,
  output logic                  pc_pause,
  output logic                  if_id_pause,
  output logic                  if_id_clear,
  output logic                  id_ex_pause,
  output logic                  id_ex_clear,
  output logic                  ex_mem_pause,
  output logic                  mem_wb_clear,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  mem_timeout
);

  localparam int FLUSH_W = 3;
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT);

  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(BR_FLUSH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_PRE   = WAIT_W'(MEM_TIMEOUT - 2);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t               state_r;
  state_t               ret_r;
  state_t               eff_state_s;
  logic [FLUSH_W-1:0]   flush_cnt_r;
  logic [WAIT_W-1:0]    wait_cnt_r;
  logic [CNT_W-1:0]     stall_cnt_r;
  logic                 mem_timeout_r;
  logic                 wait_cond_s;
  logic                 structural_s;
  logic                 load_use_s;
  logic                 rs_hit_s;
  logic                 rt_hit_s;

  // Hazard detection terms
  always_comb begin
    wait_cond_s  = mem_data_access & ~mem_ready;
    structural_s = mem_data_access & mem_ready;
    rs_hit_s     = id_rs_valid & (id_rs_addr == ex_rd_addr);
    rt_hit_s     = id_rt_valid & (id_rt_addr == ex_rd_addr);
    load_use_s   = ex_mem_read & (ex_rd_addr != {REG_ADDR_W{1'b0}}) & (rs_hit_s | rt_hit_s);
    // On the MEM_WAIT exit cycle the recorded state's rules apply
    if (state_r == ST_MEM_WAIT) begin
      eff_state_s = ret_r;
    end else begin
      eff_state_s = state_r;
    end
  end

  // Pause/clear control generation by priority
  always_comb begin
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_pause  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_pause = 1'b0;
    mem_wb_clear = 1'b0;
    if (rst) begin
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      mem_wb_clear = 1'b1;
    end else if (wait_cond_s) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_pause = 1'b1;
      mem_wb_clear = 1'b1;
    end else begin
      case (eff_state_s)
        ST_FLUSH: begin
          if_id_clear = 1'b1;
          pc_pause    = structural_s;
        end
        ST_RUN: begin
          if (ex_branch_taken) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
          end else if (load_use_s) begin
            pc_pause    = 1'b1;
            if_id_pause = 1'b1;
            id_ex_clear = 1'b1;
          end else if (structural_s) begin
            pc_pause    = 1'b1;
            if_id_clear = 1'b1;
          end else begin
            pc_pause = 1'b0;
          end
        end
        default: begin
          pc_pause = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, wait/flush counters, stall counter and timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      ret_r         <= ST_RUN;
      flush_cnt_r   <= {FLUSH_W{1'b0}};
      wait_cnt_r    <= {WAIT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      if (pc_pause && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (wait_cond_s) begin
        if (state_r != ST_MEM_WAIT) begin
          ret_r      <= state_r;
          state_r    <= ST_MEM_WAIT;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
          if (wait_cnt_r != WAIT_LAST) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
          if (wait_cnt_r == WAIT_PRE) begin
            mem_timeout_r <= 1'b1;
          end
        end
      end else begin
        case (eff_state_s)
          ST_FLUSH: begin
            flush_cnt_r <= flush_cnt_r - FLUSH_ONE;
            if (flush_cnt_r <= FLUSH_ONE) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_FLUSH;
            end
          end
          ST_RUN: begin
            if (ex_branch_taken && (BR_FLUSH > 1)) begin
              state_r     <= ST_FLUSH;
              flush_cnt_r <= FLUSH_INIT;
            end else begin
              state_r <= ST_RUN;
            end
          end
          default: begin
            state_r <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign stall_cnt   = stall_cnt_r;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two parameterisations driven with the same directed
// vectors, checked every cycle against a behavioural model plus literal pins.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_rs_valid, id_rt_valid, ex_mem_read, ex_branch_taken;
  logic       mem_data_access, mem_ready;
  logic [3:0] id_rs_addr, id_rt_addr, ex_rd_addr;

  logic        a_pc, a_ifp, a_ifc, a_idp, a_idc, a_exp, a_mwc, a_tmo;
  logic        b_pc, b_ifp, b_ifc, b_idp, b_idc, b_exp, b_mwc, b_tmo;
  logic [15:0] a_cnt, b_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit run_chk = 1'b0;

  // control bit order: {pc_pause, if_id_pause, if_id_clear, id_ex_pause,
  //                     id_ex_clear, ex_mem_pause, mem_wb_clear}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_LOAD   = 7'b1100100;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_FLUSH  = 7'b0010000;
  localparam logic [6:0] C_STRUCT = 7'b1010000;

  logic [6:0]  act_ctl [2];
  logic [15:0] act_cnt [2];
  logic        act_tmo [2];

  assign act_ctl[0] = {a_pc, a_ifp, a_ifc, a_idp, a_idc, a_exp, a_mwc};
  assign act_ctl[1] = {b_pc, b_ifp, b_ifc, b_idp, b_idc, b_exp, b_mwc};
  assign act_cnt[0] = a_cnt;
  assign act_cnt[1] = b_cnt;
  assign act_tmo[0] = a_tmo;
  assign act_tmo[1] = b_tmo;

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .BR_FLUSH(2), .MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs_valid(id_rs_valid), .id_rs_addr(id_rs_addr),
    .id_rt_valid(id_rt_valid), .id_rt_addr(id_rt_addr),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .mem_data_access(mem_data_access), .mem_ready(mem_ready),
    .pc_pause(a_pc), .if_id_pause(a_ifp), .if_id_clear(a_ifc),
    .id_ex_pause(a_idp), .id_ex_clear(a_idc), .ex_mem_pause(a_exp),
    .mem_wb_clear(a_mwc), .stall_cnt(a_cnt), .mem_timeout(a_tmo)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .BR_FLUSH(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs_valid(id_rs_valid), .id_rs_addr(id_rs_addr),
    .id_rt_valid(id_rt_valid), .id_rt_addr(id_rt_addr),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .mem_data_access(mem_data_access), .mem_ready(mem_ready),
    .pc_pause(b_pc), .if_id_pause(b_ifp), .if_id_clear(b_ifc),
    .id_ex_pause(b_idp), .id_ex_clear(b_idc), .ex_mem_pause(b_exp),
    .mem_wb_clear(b_mwc), .stall_cnt(b_cnt), .mem_timeout(b_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bf [2] = '{2, 3};
  int mt [2] = '{64, 4};
  int squash_left [2] = '{0, 0};
  bit waiting [2] = '{1'b0, 1'b0};
  int waited [2] = '{0, 0};
  bit tmo [2] = '{1'b0, 1'b0};
  int stalls [2] = '{0, 0};

  function automatic bit load_use_hit();
    return ex_mem_read && (ex_rd_addr != 4'd0) &&
           ((id_rs_valid && id_rs_addr == ex_rd_addr) || (id_rt_valid && id_rt_addr == ex_rd_addr));
  endfunction

  function automatic logic [6:0] model_ctl(input int k);
    if (rst) return C_RST;
    if (mem_data_access && !mem_ready) return C_FREEZE;
    if (squash_left[k] > 0) return mem_data_access ? C_STRUCT : C_FLUSH;
    if (ex_branch_taken) return C_BRANCH;
    if (load_use_hit()) return C_LOAD;
    if (mem_data_access) return C_STRUCT;
    return C_NONE;
  endfunction

  // Per-cycle comparison against the model, then advance the model
  initial begin
    logic [6:0] exp_ctl;
    wait (run_chk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_ctl = model_ctl(k);
        check($sformatf("ctl[%0d]", k), {25'd0, act_ctl[k]}, {25'd0, exp_ctl});
        check($sformatf("stall_cnt[%0d]", k), {16'd0, act_cnt[k]}, stalls[k]);
        check($sformatf("mem_timeout[%0d]", k), {31'd0, act_tmo[k]}, {31'd0, tmo[k]});
        if (rst) begin
          squash_left[k] = 0; waiting[k] = 1'b0; waited[k] = 0; tmo[k] = 1'b0; stalls[k] = 0;
        end else begin
          if (exp_ctl[6] && stalls[k] < 65535) stalls[k]++;
          if (mem_data_access && !mem_ready) begin
            if (!waiting[k]) begin
              waiting[k] = 1'b1;
              waited[k] = 0;
            end else begin
              waited[k]++;
              if (waited[k] >= mt[k] - 1) tmo[k] = 1'b1;
            end
          end else begin
            waiting[k] = 1'b0;
            if (squash_left[k] > 0) squash_left[k]--;
            else if (ex_branch_taken && bf[k] > 1) squash_left[k] = bf[k] - 1;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs_valid = 1'b0; id_rs_addr = 4'd0; id_rt_valid = 1'b0; id_rt_addr = 4'd0;
    ex_mem_read = 1'b0; ex_rd_addr = 4'd0; ex_branch_taken = 1'b0;
    mem_data_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;
    check("rst_ctl", {25'd0, act_ctl[0]}, {25'd0, C_RST});
    cyc();
    rst = 1'b0;
    #1;
    // 1: first cycle out of reset
    check("s1_ctl", {25'd0, act_ctl[0]}, {25'd0, C_NONE});
    check("s1_cnt", {16'd0, a_cnt}, 32'd0);
    check("s1_tmo", {31'd0, a_tmo}, 32'd0);
    cyc();

    // 2: load-use via rs, rd=0, via rt, invalid rs, non-load
    ex_mem_read = 1'b1; ex_rd_addr = 4'd3; id_rs_valid = 1'b1; id_rs_addr = 4'd3;
    #1; check("s2_lu_ctl", {25'd0, act_ctl[0]}, {25'd0, C_LOAD});
    cyc(); clr_in(); #1;
    check("s2_after_ctl", {25'd0, act_ctl[0]}, {25'd0, C_NONE});
    check("s2_cnt1", {16'd0, a_cnt}, 32'd1);
    ex_mem_read = 1'b1; ex_rd_addr = 4'd0; id_rs_valid = 1'b1; id_rs_addr = 4'd0;
    #1; check("s2_rd0_ctl", {25'd0, act_ctl[0]}, {25'd0, C_NONE});
    cyc(); clr_in();
    ex_mem_read = 1'b1; ex_rd_addr = 4'd5; id_rt_valid = 1'b1; id_rt_addr = 4'd5; id_rs_addr = 4'd5;
    #1; check("s2_rt_ctl", {25'd0, act_ctl[0]}, {25'd0, C_LOAD});
    cyc(); clr_in();
    ex_mem_read = 1'b1; ex_rd_addr = 4'd5; id_rs_addr = 4'd5; id_rt_valid = 1'b1; id_rt_addr = 4'd6;
    #1; check("s2_norv_ctl", {25'd0, act_ctl[0]}, {25'd0, C_NONE});
    cyc(); clr_in();
    ex_rd_addr = 4'd7; id_rs_valid = 1'b1; id_rs_addr = 4'd7;
    cyc(); clr_in(); #1;
    check("s2_cnt2", {16'd0, a_cnt}, 32'd2);

    // 3: branch overrides same-cycle load-use
    do_reset();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 4'd3; id_rs_valid = 1'b1; id_rs_addr = 4'd3;
    #1; check("s3_c0", {25'd0, act_ctl[0]}, {25'd0, C_BRANCH});
    cyc(); clr_in(); #1;
    check("s3_c1", {25'd0, act_ctl[0]}, {25'd0, C_FLUSH});
    cyc(); #1;
    check("s3_c2", {25'd0, act_ctl[0]}, {25'd0, C_NONE});
    check("s3_cnt", {16'd0, a_cnt}, 32'd0);

    // 4: five-cycle RAM wait then ready
    do_reset();
    mem_data_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; check("s4_freeze", {25'd0, act_ctl[0]}, {25'd0, C_FREEZE});
      cyc();
    end
    mem_ready = 1'b1;
    #1; check("s4_ready", {25'd0, act_ctl[0]}, {25'd0, C_STRUCT});
    cyc(); clr_in(); #1;
    check("s4_cnt6", {16'd0, a_cnt}, 32'd6);
    check("s4_b_tmo", {31'd0, b_tmo}, 32'd1);
    check("s4_a_tmo", {31'd0, a_tmo}, 32'd0);

    // 5: timeout after MEM_TIMEOUT wait cycles, sticky until reset
    do_reset();
    mem_data_access = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      #1; check($sformatf("s5_tmo_c%0d", i), {31'd0, a_tmo}, (i >= 65) ? 32'd1 : 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    cyc(); clr_in(); cyc(); #1;
    check("s5_sticky", {31'd0, a_tmo}, 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    check("s5_cleared", {31'd0, a_tmo}, 32'd0);

    // 6: RAM wait inside a 3-cycle flush, then reset mid-wait
    do_reset();
    ex_branch_taken = 1'b1;
    #1; check("s6_br", {25'd0, act_ctl[1]}, {25'd0, C_BRANCH});
    cyc(); clr_in();
    mem_data_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check("s6_freeze", {25'd0, act_ctl[1]}, {25'd0, C_FREEZE});
      cyc();
    end
    mem_ready = 1'b1;
    #1; check("s6_ready", {25'd0, act_ctl[1]}, {25'd0, C_STRUCT});
    cyc(); clr_in(); #1;
    check("s6_last_flush", {25'd0, act_ctl[1]}, {25'd0, C_FLUSH});
    cyc(); #1;
    check("s6_run", {25'd0, act_ctl[1]}, {25'd0, C_NONE});
    mem_data_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    #1; check("s6_pre_rst_tmo", {31'd0, b_tmo}, 32'd1);
    rst = 1'b1;
    #1; check("s6_rst_ctl", {25'd0, act_ctl[1]}, {25'd0, C_RST});
    cyc(); rst = 1'b0; clr_in(); #1;
    check("s6_post_ctl", {25'd0, act_ctl[1]}, {25'd0, C_NONE});
    check("s6_post_cnt", {16'd0, b_cnt}, 32'd0);
    check("s6_post_tmo", {31'd0, b_tmo}, 32'd0);
    ex_mem_read = 1'b1; ex_rd_addr = 4'd9; id_rt_valid = 1'b1; id_rt_addr = 4'd9;
    #1; check("s6_post_lu", {25'd0, act_ctl[1]}, {25'd0, C_LOAD});
    cyc(); clr_in(); cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
